// File: rtl/wb_b3_arbiter_2m.sv
// Two-master / one-slave Wishbone B3 arbiter feeding the external RAM port.
// Round-robin with burst-atomic grants and a stalled-transfer watchdog.
module wb_b3_arbiter_2m #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [2:0]        m0_cti_i,
  input  logic [1:0]        m0_bte_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,

  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [2:0]        m1_cti_i,
  input  logic [1:0]        m1_bte_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,

  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,

  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam bit WD_EN = (TIMEOUT != 0);

  state_t        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [TW-1:0] wd_q, wd_d;

  logic own_stb;
  logic s_term;
  logic abort;

  always_comb begin
    own_stb = 1'b0;
    case (state_q)
      GNT0:    own_stb = m0_cyc_i & m0_stb_i;
      GNT1:    own_stb = m1_cyc_i & m1_stb_i;
      default: own_stb = 1'b0;
    endcase
  end

  assign s_term = s_ack_i | s_err_i | s_rty_i;
  assign abort  = WD_EN && own_stb && (wd_q == TW'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_owner_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0 && state_q != GNT0) last_owner_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_owner_d = 1'b1;
  end

  // Counts only uninterrupted stalled strobe cycles within one grant.
  always_comb begin
    wd_d = '0;
    if (WD_EN && (state_d == state_q) && own_stb && !s_term && !abort)
      wd_d = wd_q + TW'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_cti_o  = m0_cti_i;
    s_bte_o  = m0_bte_i;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    grant_o  = 2'b00;
    case (state_q)
      GNT0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_cyc_i & ~abort;
        s_stb_o  = m0_stb_i & ~abort;
        s_we_o   = m0_we_i;
        m0_ack_o = s_ack_i & ~abort;
        m0_err_o = s_err_i | abort;
        m0_rty_o = s_rty_i & ~abort;
      end
      GNT1: begin
        grant_o  = 2'b10;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_cyc_o  = m1_cyc_i & ~abort;
        s_stb_o  = m1_stb_i & ~abort;
        s_we_o   = m1_we_i;
        m1_ack_o = s_ack_i & ~abort;
        m1_err_o = s_err_i | abort;
        m1_rty_o = s_rty_i & ~abort;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_b3_arbiter_2m.md
Name: wb_b3_arbiter_2m

Overview:
- Two-master, one-slave Wishbone B3 arbiter that sits directly upstream of the external memory (wb_ram) slave port.
- Master 0 is the SoC external bus (the wb_ext_* port of top_woodchuck). Master 1 is the debug-side memory access path, used for host boot-block loading and memory inspection.
- Arbitration is round-robin with burst-atomic grants, and a bus-timeout watchdog prevents a hung transfer from locking out the other master.

Parameters:
- AW, 32, address width of all adr ports.
- DW, 32, data width; select width is DW/8.
- TIMEOUT, 1024, cycles stb may stay asserted without ack/err/rty before abort; 0 disables the watchdog.
- TW, 16, width of the watchdog counter; must satisfy TIMEOUT < 2**TW.

Ports:
- wb_clk_i  input  1  clock, all logic rising-edge.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- m0_adr_i/m1_adr_i  input  AW each  master address.
- m0_dat_i/m1_dat_i  input  DW each  master write data.
- m0_sel_i/m1_sel_i  input  DW/8 each  byte selects.
- m0_cyc_i/m1_cyc_i, m0_stb_i/m1_stb_i, m0_we_i/m1_we_i  input  1 each  cycle, strobe, write enable.
- m0_cti_i/m1_cti_i  input  3 each  cycle type.
- m0_bte_i/m1_bte_i  input  2 each  burst type.
- m0_dat_o/m1_dat_o  output  DW each  read data.
- m0_ack_o/m1_ack_o, m0_err_o/m1_err_o, m0_rty_o/m1_rty_o  output  1 each  terminations.
- s_adr_o AW, s_dat_o DW, s_sel_o DW/8, s_cyc_o 1, s_stb_o 1, s_we_o 1, s_cti_o 3, s_bte_o 2  output  slave request.
- s_dat_i DW, s_ack_i 1, s_err_i 1, s_rty_i 1  input  slave response.
- grant_o  output  2  one-hot current owner (debug visibility).

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Register last_owner; reset value 1, so master 0 wins the first tie.
- On reset (asynchronous assertion, any state including mid-burst): state=IDLE, grant_o=00, watchdog=0.
  - All master ack/err/rty and s_cyc_o/s_stb_o/s_we_o are 0 while wb_rst_i is high and in IDLE.
  - s_adr_o/s_dat_o/s_sel_o/s_cti_o/s_bte_o carry m0 values in IDLE.
- IDLE: if exactly one mX_cyc_i is high, go to GNTX at the next edge. If both are high, go to the master != last_owner. Arbitration latency is 1 cycle; the slave first sees the request on the cycle after cyc is sampled.
- GNTX: slave request ports are combinational copies of master X.
  - mX_ack/err/rty_o = s_ack/err/rty_i; both mX_dat_o = s_dat_i.
  - The non-owner's ack/err/rty are forced 0, and its stb is never forwarded.
  - Set last_owner=X on entry.
- Grant is held while mX_cyc_i stays high, regardless of cti. Bursts (cti 001/010) and cycles split by stb gaps are never interrupted.
- Release happens when mX_cyc_i is low at a rising edge:
  - if the other master's cyc is high, go directly to GNT(other), with no idle cycle;
  - otherwise go to IDLE.
- s_cyc_o = owner's cyc & grant. The slave never sees cyc from a non-owner.
- Watchdog:
  - The counter increments each cycle the owner has stb high and s_ack_i|s_err_i|s_rty_i is low.
  - It clears on any termination, when stb is low, or on a state change.
  - When the counter reaches TIMEOUT, the cycle is an abort cycle:
    - s_cyc_o and s_stb_o are forced 0;
    - owner err_o=1 for exactly that cycle; owner ack_o=0;
    - the counter clears.
  - Grant is still held until the owner drops cyc.
- If the slave asserts ack and err in the same cycle, both are passed through; the arbiter does not resolve them.
- No internal buffering: data and terminations are zero-latency pass-through once granted.

Test Plan:
- Single master: m1 issues a classic read at adr 0x100, slave returns 0xDEADBEEF. Required: s_cyc_o rises 1 cycle after m1_cyc_i; m1_ack_o=1 with m1_dat_o=0xDEADBEEF; m0_ack_o stays 0; grant_o=10.
- Tie after reset: m0 and m1 raise cyc in the same cycle. Required: grant_o=01 first. When m0 drops cyc, grant switches directly to 10 with zero IDLE cycles. A following tie is won by m0.
- Burst atomicity: m0 runs a 4-beat incrementing burst (cti 010,010,010,111, bte 00) at 0x0. m1 requests at beat 2. Required: all 4 m0 acks are delivered; m1 is granted only on the edge after m0_cyc_i falls.
- Watchdog: TIMEOUT=8, slave never acks m0's stb. Required: on stb cycle 9 (counter=8), m0_err_o pulses for exactly 1 cycle and s_stb_o=0 in that cycle. grant_o stays 01 until m0 drops cyc.
- Reset mid-burst: assert wb_rst_i asynchronously between clock edges during beat 2 of an m1 burst. Required: grant_o=00 and s_cyc_o=0 immediately, without waiting for a clock edge. After release, the first tie goes to m0.
- TIMEOUT=0 with a 5000-cycle slave stall: no err is generated and the ack eventually passes through unchanged.
